hilo_issue_ctrl: RTL and testbench

- Initiator side of the multi-cycle multiply/divide unit. Sits in the execute stage.
- Accepts decoded HI/LO-class instructions and drives the unit's command inputs, holding them stable for the whole operation.
- Owns the architectural HI/LO registers, commits the unit's results, serves MFHI/MFLO reads and MTHI/MTLO writes, and stalls the pipeline while busy.

---
 rtl/hilo_pkg.sv | 26 ++
 rtl/hilo_issue_ctrl_decode.sv | 24 ++
 rtl/hilo_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_hilo_issue_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO issue controller: decoded ops, FSM states and unit command bits.
package hilo_pkg;

  typedef enum logic [3:0] {
    NOP, MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, MFHI, MFLO
  } hilo_op_t;

  typedef logic [1:0] state_t;
  localparam state_t IDLE        = 2'd0;
  localparam state_t BUSY        = 2'd1;
  localparam state_t COMMIT_WAIT = 2'd2;

  typedef struct packed {
    logic mul;
    logic div;
    logic using_sign;
    logic add;
    logic sub;
  } hilo_cmd_t;

  // Ops that occupy the multiply/divide unit for several cycles.
  function automatic logic is_unit_op(input hilo_op_t op);
    return op inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
  endfunction

endpackage

// File: rtl/hilo_issue_ctrl_decode.sv
// Combinational decode of a HI/LO-class op into multiply/divide unit command bits.
module hilo_cmd_decode
  import hilo_pkg::*;
(
  input  hilo_op_t  op_i,
  output hilo_cmd_t cmd_o
);

  always_comb begin
    cmd_o = '0;
    case (op_i)
      MULT:    begin cmd_o.mul = 1'b1; cmd_o.using_sign = 1'b1; end
      MULTU:   cmd_o.mul = 1'b1;
      DIV:     begin cmd_o.div = 1'b1; cmd_o.using_sign = 1'b1; end
      DIVU:    cmd_o.div = 1'b1;
      MADD:    begin cmd_o.mul = 1'b1; cmd_o.using_sign = 1'b1; cmd_o.add = 1'b1; end
      MADDU:   begin cmd_o.mul = 1'b1; cmd_o.add = 1'b1; end
      MSUB:    begin cmd_o.mul = 1'b1; cmd_o.using_sign = 1'b1; cmd_o.sub = 1'b1; end
      MSUBU:   begin cmd_o.mul = 1'b1; cmd_o.sub = 1'b1; end
      default: cmd_o = '0;
    endcase
  end

endmodule

// File: rtl/hilo_issue_ctrl.sv
// Execute-stage initiator for the multi-cycle mul/div unit; owns architectural HI/LO,
// holds unit commands for the whole operation and stalls the pipe while an op is in flight.
module hilo_issue_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_valid,
  input  hilo_op_t     op,
  input  logic [N-1:0] src_a,
  input  logic [N-1:0] src_b,
  input  logic         flush,
  input  logic         wb_hold,
  output logic         stall,
  output logic [N-1:0] mf_data,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         u_mul,
  output logic         u_div,
  output logic         u_using_sign,
  output logic         u_sub,
  output logic         u_add,
  output logic [N-1:0] u_a,
  output logic [N-1:0] u_b,
  output logic [N-1:0] u_hi_in,
  output logic [N-1:0] u_lo_in,
  output logic         u_clear,
  output logic         u_hold_result,
  input  logic [N-1:0] u_hi_out,
  input  logic [N-1:0] u_lo_out,
  input  logic         u_write_hi_lo,
  input  logic         u_waiting_result
);

  state_t       state_q, state_d;
  logic [N-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  hilo_cmd_t    cmd_q, cmd_d, dec_cmd;

  logic in_flight, result_ready, commit, accept;

  hilo_cmd_decode u_decode (
    .op_i  (op),
    .cmd_o (dec_cmd)
  );

  // Result is "ready" while the unit presents it in BUSY, or for the whole COMMIT_WAIT span.
  assign in_flight    = (state_q != IDLE);
  assign result_ready = in_flight && !flush && ((state_q == COMMIT_WAIT) || u_write_hi_lo);
  assign commit       = result_ready && !wb_hold;
  assign stall        = op_valid && in_flight && (op != NOP);
  assign accept       = op_valid && !stall && (op != NOP) && !flush;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    cmd_d   = cmd_q;
    if (flush) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      cmd_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_unit_op(op)) begin
              state_d = BUSY;
              a_d     = src_a;
              b_d     = src_b;
              cmd_d   = dec_cmd;
            end else if (op == MTHI) begin
              hi_d = src_a;
            end else if (op == MTLO) begin
              lo_d = src_a;
            end
          end
        end
        BUSY, COMMIT_WAIT: begin
          if (commit) begin
            state_d = IDLE;
            hi_d    = u_hi_out;
            lo_d    = u_lo_out;
            a_d     = '0;
            b_d     = '0;
            cmd_d   = '0;
          end else if (result_ready) begin
            state_d = COMMIT_WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cmd_q   <= cmd_d;
    end
  end

  // Start/sign commands drop on the commit and flush cycles so the unit never restarts.
  always_comb begin
    u_mul         = cmd_q.mul        && in_flight && !commit && !flush;
    u_div         = cmd_q.div        && in_flight && !commit && !flush;
    u_using_sign  = cmd_q.using_sign && in_flight && !commit && !flush;
    u_add         = cmd_q.add;
    u_sub         = cmd_q.sub;
    u_a           = a_q;
    u_b           = b_q;
    u_hi_in       = hi_q;
    u_lo_in       = lo_q;
    u_clear       = flush;
    u_hold_result = result_ready && wb_hold;
    mf_data       = (op == MFHI) ? hi_q : lo_q;
    hi            = hi_q;
    lo            = lo_q;
  end

  busy_unit_waiting_a : assert property (@(posedge clk) disable iff (reset)
    ((state_q == BUSY) && !u_write_hi_lo && !flush) |-> u_waiting_result);

endmodule

// File: tb/tb_hilo_issue_ctrl.sv
// Self-checking bench for hilo_issue_ctrl: behavioural mul/div unit, spec-level
// reference model compared every cycle, plus directed literal checks.
module tb_hilo_issue_ctrl;
  import hilo_pkg::*;

  localparam int unsigned N   = 32;
  localparam int          LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_valid;
  hilo_op_t     op;
  logic [N-1:0] src_a, src_b;
  logic         flush, wb_hold;
  logic         stall;
  logic [N-1:0] mf_data, hi, lo;
  logic         u_mul, u_div, u_using_sign, u_sub, u_add;
  logic [N-1:0] u_a, u_b, u_hi_in, u_lo_in;
  logic         u_clear, u_hold_result;
  logic [N-1:0] u_hi_out, u_lo_out;
  logic         u_write_hi_lo, u_waiting_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_issue_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .wb_hold(wb_hold), .stall(stall), .mf_data(mf_data), .hi(hi), .lo(lo),
    .u_mul(u_mul), .u_div(u_div), .u_using_sign(u_using_sign), .u_sub(u_sub), .u_add(u_add),
    .u_a(u_a), .u_b(u_b), .u_hi_in(u_hi_in), .u_lo_in(u_lo_in), .u_clear(u_clear),
    .u_hold_result(u_hold_result), .u_hi_out(u_hi_out), .u_lo_out(u_lo_out),
    .u_write_hi_lo(u_write_hi_lo), .u_waiting_result(u_waiting_result)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural multiply/divide unit ----------------
  function automatic logic [63:0] unit_calc(input logic div_f, sgn, add_f, sub_f,
                                            input logic [31:0] a, b, hv, lv);
    logic [63:0] ea, eb, prod;
    logic [31:0] q, r;
    if (div_f) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
      return {r, q};
    end
    ea   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb   = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod = ea * eb;
    if (add_f) return {hv, lv} + prod;
    if (sub_f) return {hv, lv} - prod;
    return prod;
  endfunction

  logic u_running;
  int   u_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      u_running <= 1'b0; u_cnt <= 0; u_write_hi_lo <= 1'b0;
      u_hi_out <= '0; u_lo_out <= '0;
    end else if (u_clear) begin
      u_running <= 1'b0; u_cnt <= 0; u_write_hi_lo <= 1'b0;
    end else if (u_write_hi_lo) begin
      if (!u_hold_result) begin
        u_write_hi_lo <= 1'b0; u_running <= 1'b0;
      end
    end else if (u_running) begin
      if (u_cnt == LAT - 1) begin
        u_write_hi_lo <= 1'b1;
        {u_hi_out, u_lo_out} <= unit_calc(u_div, u_using_sign, u_add, u_sub,
                                          u_a, u_b, u_hi_in, u_lo_in);
      end else begin
        u_cnt <= u_cnt + 1;
      end
    end else if (u_mul || u_div) begin
      u_running <= 1'b1; u_cnt <= 0;
    end
  end

  assign u_waiting_result = (u_running || u_mul || u_div) && !u_write_hi_lo;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_calc(input hilo_op_t o, input logic [31:0] a, b, hv, lv);
    longint sa, sb;
    logic [63:0] acc, sp, up;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sp  = 64'(sa * sb);
    up  = 64'(a) * 64'(b);
    acc = {hv, lv};
    case (o)
      MULT:  return sp;
      MULTU: return up;
      MADD:  return acc + sp;
      MADDU: return acc + up;
      MSUB:  return acc - sp;
      MSUBU: return acc - up;
      DIV:   return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(int'(a) % int'(b)), 32'(int'(a) / int'(b))};
      DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: return acc;
    endcase
  endfunction

  bit          m_busy = 0, m_cw = 0, m_accept = 0;
  hilo_op_t    m_op = NOP;
  logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
  bit          e_ready, e_commit, e_run, e_div, e_sgn, e_add, e_sub;

  always @(negedge clk) begin
    if (reset) begin
      m_busy = 0; m_cw = 0; m_accept = 0; m_hi = '0; m_lo = '0;
    end else begin
      e_ready  = m_busy && !flush && (m_cw || u_write_hi_lo);
      e_commit = e_ready && !wb_hold;
      e_run    = m_busy && !flush && !e_commit;
      e_div    = m_op inside {DIV, DIVU};
      e_sgn    = m_op inside {MULT, DIV, MADD, MSUB};
      e_add    = m_op inside {MADD, MADDU};
      e_sub    = m_op inside {MSUB, MSUBU};
      chk("stall", 64'(stall), 64'(op_valid && m_busy && op != NOP));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("u_clear", 64'(u_clear), 64'(flush));
      chk("u_hold_result", 64'(u_hold_result), 64'(e_ready && wb_hold));
      chk("u_mul", 64'(u_mul), 64'(e_run && !e_div));
      chk("u_div", 64'(u_div), 64'(e_run && e_div));
      chk("u_using_sign", 64'(u_using_sign), 64'(e_run && e_sgn));
      chk("u_add", 64'(u_add), 64'(m_busy && e_add));
      chk("u_sub", 64'(u_sub), 64'(m_busy && e_sub));
      chk("u_a", 64'(u_a), 64'(m_busy ? m_a : 32'd0));
      chk("u_b", 64'(u_b), 64'(m_busy ? m_b : 32'd0));
      chk("u_hi_in", 64'(u_hi_in), 64'(m_hi));
      chk("u_lo_in", 64'(u_lo_in), 64'(m_lo));
      if (op_valid && (op == MFHI || op == MFLO))
        chk("mf_data", 64'(mf_data), 64'((op == MFHI) ? m_hi : m_lo));
      // advance model to the state after the coming edge
      m_accept = 0;
      if (flush) begin
        m_busy = 0; m_cw = 0;
      end else if (m_busy) begin
        if (e_commit) begin
          m_hi = m_rhi; m_lo = m_rlo; m_busy = 0; m_cw = 0;
        end else if (e_ready) begin
          m_cw = 1;
        end
      end else if (op_valid && op != NOP) begin
        m_accept = 1;
        if (is_unit_op(op)) begin
          m_busy = 1; m_op = op; m_a = src_a; m_b = src_b;
          {m_rhi, m_rlo} = ref_calc(op, src_a, src_b, m_hi, m_lo);
        end else if (op == MTHI) begin
          m_hi = src_a;
        end else if (op == MTLO) begin
          m_lo = src_a;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input hilo_op_t o, input logic [31:0] a, input logic [31:0] b);
    bit done = 0;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      done = m_accept;
    end
    if (!done) chk("issue_timeout", 64'd0, 64'd1);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      done = !m_busy;
    end
    if (!done) chk("idle_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic wait_result();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      done = u_write_hi_lo;
    end
    if (!done) chk("result_timeout", 64'd0, 64'd1);
  endtask

  int hold_cnt;

  initial begin
    reset = 1'b1; op_valid = 1'b1; op = MULT; src_a = '0; src_b = '0;
    flush = 1'b0; wb_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_u_mul", 64'(u_mul), 64'd0);
    reset = 1'b0; op_valid = 1'b0;

    // Signed op sitting on the bus while not valid must not start the unit.
    op = MULT; src_a = 32'h8000_0000; src_b = 32'd3;
    repeat (3) begin
      @(negedge clk);
      chk("idle_sign", 64'(u_using_sign), 64'd0);
      chk("idle_mul", 64'(u_mul), 64'd0);
      chk("idle_waiting", 64'(u_waiting_result), 64'd0);
    end
    @(posedge clk); #1;

    // MULT -3 * 5, MFHI queued behind it
    issue(MULT, 32'hFFFF_FFFD, 32'd5);
    op_valid = 1'b1; op = MFHI;
    @(negedge clk);
    chk("mult_busy_stall", 64'(stall), 64'd1);
    issue(MFHI, 32'd0, 32'd0);
    chk("mult_mfhi", 64'(mf_data), 64'hFFFF_FFFF);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);
    chk("model_mult_lo", 64'(m_lo), 64'hFFFF_FFF1);
    chk("mult_idle_after", 64'(u_mul), 64'd0);

    // DIVU 100/7 with a dependent MFLO
    issue(DIVU, 32'd100, 32'd7);
    issue(MFLO, 32'd0, 32'd0);
    chk("divu_mflo", 64'(mf_data), 64'h0000_000E);
    chk("divu_hi", 64'(hi), 64'h0000_0002);

    // Accumulate path
    issue(MTHI, 32'd0, 32'd0);
    issue(MTLO, 32'd10, 32'd0);
    issue(MADD, 32'd3, 32'd4);
    chk("madd_lo_in", 64'(u_lo_in), 64'd10);
    chk("madd_add", 64'(u_add), 64'd1);
    wait_idle();
    chk("madd_lo", 64'(lo), 64'd22);
    chk("madd_hi", 64'(hi), 64'd0);
    issue(MSUBU, 32'd2, 32'd11);
    wait_idle();
    chk("msubu_lo", 64'(lo), 64'd0);
    chk("msubu_hi", 64'(hi), 64'd0);

    // Writeback backpressure for three result cycles
    wb_hold = 1'b1;
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result();
    hold_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (u_hold_result) hold_cnt++;
      chk("hold_hi_unchanged", 64'(hi), 64'd0);
      @(posedge clk); #1;
    end
    wb_hold = 1'b0;
    @(negedge clk);
    chk("hold_release", 64'(u_hold_result), 64'd0);
    @(posedge clk); #1;
    chk("hold_cycles", 64'(hold_cnt), 64'd3);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);

    // Flush a DIV mid-flight
    issue(DIV, 32'hFFFF_FF9C, 32'd7);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_clear", 64'(u_clear), 64'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_clear_pulse", 64'(u_clear), 64'd0);
    chk("flush_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("flush_lo", 64'(lo), 64'h0000_0001);
    @(posedge clk); #1;
    issue(MULT, 32'd2, 32'd3);
    wait_idle();
    chk("post_flush_lo", 64'(lo), 64'd6);

    // Flush on the very cycle the result is presented
    issue(MULTU, 32'd7, 32'd9);
    wait_result();
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("flush_on_result_lo", 64'(lo), 64'd6);

    // Op presented together with flush is dropped
    flush = 1'b1; op_valid = 1'b1; op = MTHI; src_a = 32'h55;
    @(posedge clk); #1 flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("flush_drops_mthi", 64'(hi), 64'd0);

    // Signed divide and divide by zero
    issue(DIV, 32'hFFFF_FF9C, 32'd7);
    wait_idle();
    chk("div_lo", 64'(lo), 64'hFFFF_FFF2);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFE);
    issue(DIVU, 32'd9, 32'd0);
    wait_idle();
    chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("div0_hi", 64'(hi), 64'd9);

    // Reset mid-operation
    issue(MULT, 32'd5, 32'd6);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_mul", 64'(u_mul), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    issue(MULT, 32'd2, 32'd3);
    wait_idle();
    chk("after_rst_lo", 64'(lo), 64'd6);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
